// File: rtl/uart_stream_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_stream_rx
// Brief   : 8N1 UART receiver feeding a small byte FIFO with an AXI-Stream-like
//           output; o_tlast marks the 8'h0A line terminator. Defining
//           UART_RX_FRAME_ERR_EN enables stop-bit checking and o_frame_err.
// Revision: 1.0 - initial release
// ============================================================================
module uart_stream_rx #(
    parameter int DIVISOR = 139,
    parameter int DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_overrun,
    output logic       o_frame_err
);

    localparam int          c_ADDR_W = $clog2(DEPTH);
    localparam logic [15:0] c_HALF   = 16'(DIVISOR / 2);
    localparam logic [15:0] c_FULL   = 16'(DIVISOR);

`ifdef UART_RX_FRAME_ERR_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
    } state_t;
`endif

    logic                r_sync_meta;
    logic                r_sync_rx;
    state_t              r_state;
    logic [15:0]         r_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic [7:0]          r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic                r_overrun;

    logic w_expire;
    logic w_stop_sample;
    logic w_push_try;
    logic w_full;
    logic w_pop;
    logic w_push;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync_meta <= 1'b1;
            r_sync_rx   <= 1'b1;
        end else begin
            r_sync_meta <= i_uart_rx;
            r_sync_rx   <= r_sync_meta;
        end
    end

    assign w_expire      = (r_cnt == 16'd1);
    assign w_stop_sample = (r_state == ST_STOP) && w_expire;

    // Receive FSM: the counter expiring at 1 marks each mid-bit sample point.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_sync_rx) begin
                        r_state <= ST_START;
                        r_cnt   <= c_HALF;
                    end
                end
                ST_START: begin
                    if (w_expire) begin
                        if (!r_sync_rx) begin
                            r_state   <= ST_DATA;
                            r_cnt     <= c_FULL;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_expire) begin
                        r_shift <= {r_sync_rx, r_shift[7:1]};
                        r_cnt   <= c_FULL;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_expire) begin
`ifdef UART_RX_FRAME_ERR_EN
                        r_state <= r_sync_rx ? ST_IDLE : ST_WAIT_HIGH;
`else
                        r_state <= ST_IDLE;
`endif
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
`ifdef UART_RX_FRAME_ERR_EN
                ST_WAIT_HIGH: begin
                    // A held-low line (break) must not look like a new start bit.
                    if (r_sync_rx) begin
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    logic r_frame_err;
    logic w_frame_bad;

    assign w_push_try  = w_stop_sample && r_sync_rx;
    assign w_frame_bad = w_stop_sample && !r_sync_rx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
        end
    end

    assign o_frame_err = r_frame_err;
`else
    assign w_push_try  = w_stop_sample;
    assign o_frame_err = 1'b0;
`endif

    assign w_full   = (r_count == (c_ADDR_W + 1)'(DEPTH));
    assign o_tvalid = (r_count != '0);
    assign w_pop    = o_tvalid && i_tready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push   = w_push_try && (!w_full || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overrun <= w_push_try && w_full && !w_pop;
        end
    end

    assign o_tdata   = r_mem[r_rd_ptr];
    assign o_tlast   = (o_tdata == 8'h0A);
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_stream_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_stream_rx
// Brief   : Self-checking bench for uart_stream_rx (DIVISOR=16, DEPTH=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_stream_rx;

    localparam int c_DIV   = 16;
    localparam int c_DEPTH = 4;
    localparam int c_LAT   = 3 + c_DIV / 2 + 9 * c_DIV;

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;
    logic       tvalid;
    logic       overrun;
    logic       frame_err;

    typedef struct {
        logic [7:0] data;
        logic       exp_last;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         cyc;
    } xfer_t;

    xfer_t      rx_q[$];
    logic [7:0] exp_q[$];
    vec_t       vecs[8];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ovr_cnt = 0;
    int   ferr_cnt = 0;
    logic rand_ready = 1'b0;
    logic hold_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_stream_rx #(
        .DIVISOR(c_DIV),
        .DEPTH  (c_DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_uart_rx  (uart_rx),
        .o_tdata    (tdata),
        .o_tlast    (tlast),
        .o_tvalid   (tvalid),
        .i_tready   (tready),
        .o_overrun  (overrun),
        .o_frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            tready = ($urandom_range(0, 3) != 0);
        end
    end

    // Stream monitor: collects transfers and checks the continuous output rules.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (tvalid) begin
                total++;
                if (tlast !== (tdata == 8'h0A)) begin
                    bad++;
                    $display("FAIL tlast_rule: got tlast=%0b for tdata=%02h", tlast, tdata);
                end
            end
            if (tvalid && hold_prev) begin
                total++;
                if (tdata !== prev_data) begin
                    bad++;
                    $display("FAIL hold_stable: got %02h want %02h", tdata, prev_data);
                end
            end
            if (tvalid && tready) rx_q.push_back('{tdata, tlast, cyc});
            if (overrun) ovr_cnt++;
            if (frame_err) ferr_cnt++;
            hold_prev = tvalid && !tready;
            prev_data = tdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        repeat (c_DIV) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic expect_rx(input string name, input logic [7:0] d, input logic last);
        xfer_t x;
        if (rx_q.size() == 0) begin
            check({name, "_present"}, 0, 1);
        end else begin
            x = rx_q.pop_front();
            check({name, "_data"}, 32'(x.data), 32'(d));
            check({name, "_last"}, 32'(x.last), 32'(last));
        end
    endtask

    initial begin
        int t0;
        logic [7:0] b;
        xfer_t x;

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h0A, 1'b1};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h55, 1'b0};
        vecs[5] = '{8'h80, 1'b0};
        vecs[6] = '{8'h01, 1'b0};
        vecs[7] = '{8'h0B, 1'b0};

        rst = 1'b1;
        uart_rx = 1'b1;
        tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(tvalid), 0);
        check("rst_tdata", 32'(tdata), 0);
        check("rst_tlast", 32'(tlast), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        rst = 1'b0;
        idle(10);

        // Table vectors with exact push-to-valid latency
        tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].data, 1'b1, t0);
            if (rx_q.size() == 0) begin
                check("tbl_present", 0, 1);
            end else begin
                x = rx_q.pop_front();
                check("tbl_data", 32'(x.data), 32'(vecs[i].data));
                check("tbl_last", 32'(x.last), 32'(vecs[i].exp_last));
                check("tbl_latency", 32'(x.cyc), 32'(t0 + c_LAT));
            end
            idle(3);
        end
        check("tbl_extra", 32'(rx_q.size()), 0);

        // Two back-to-back frames held in the FIFO, then drained
        tready = 1'b0;
        send_frame(8'h0A, 1'b1, t0);
        send_frame(8'h41, 1'b1, t0);
        idle(5);
        check("b2b_tvalid", 32'(tvalid), 1);
        check("b2b_head", 32'(tdata), 32'h0A);
        tready = 1'b1;
        idle(5);
        check("b2b_count", 32'(rx_q.size()), 2);
        expect_rx("b2b0", 8'h0A, 1'b1);
        expect_rx("b2b1", 8'h41, 1'b0);

        // Overrun: fifth byte into a full FIFO is dropped
        tready = 1'b0;
        ovr_cnt = 0;
        for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, t0);
        idle(3);
        check("ovr_before5", 32'(ovr_cnt), 0);
        send_frame(8'h05, 1'b1, t0);
        idle(3);
        check("ovr_on5", 32'(ovr_cnt), 1);
        tready = 1'b1;
        idle(10);
        check("ovr_drain_count", 32'(rx_q.size()), 4);
        for (int k = 1; k <= 4; k++) expect_rx("ovr_drain", 8'(k), 1'b0);

        // Short low glitch on an idle line
        uart_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(40);
        check("glitch_nopush", 32'(rx_q.size()), 0);
        check("glitch_tvalid", 32'(tvalid), 0);
        send_frame(8'h3C, 1'b1, t0);
        idle(5);
        check("glitch_after_count", 32'(rx_q.size()), 1);
        expect_rx("glitch_after", 8'h3C, 1'b0);

        // Stop bit low, then a good frame
        ferr_cnt = 0;
        send_frame(8'h55, 1'b0, t0);
        idle(40);
        send_frame(8'h33, 1'b1, t0);
        idle(10);
`ifdef UART_RX_FRAME_ERR_EN
        check("ferr_pulses", 32'(ferr_cnt), 1);
        check("ferr_count", 32'(rx_q.size()), 1);
`else
        check("ferr_pulses", 32'(ferr_cnt), 0);
        check("ferr_count", 32'(rx_q.size()), 2);
        expect_rx("ferr_kept", 8'h55, 1'b0);
`endif
        expect_rx("ferr_next", 8'h33, 1'b0);

        // Reset during data bit 4 with a byte already queued
        tready = 1'b0;
        send_frame(8'h77, 1'b1, t0);
        idle(5);
        check("mid_pre_tvalid", 32'(tvalid), 1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        uart_rx = 1'b1;
        repeat (c_DIV / 2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_tvalid", 32'(tvalid), 0);
        check("mid_rst_tdata", 32'(tdata), 0);
        check("mid_rst_tlast", 32'(tlast), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        check("mid_rst_frame_err", 32'(frame_err), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(30);
        tready = 1'b1;
        idle(5);
        send_frame(8'h12, 1'b1, t0);
        idle(10);
        check("mid_after_count", 32'(rx_q.size()), 1);
        expect_rx("mid_after", 8'h12, 1'b0);

        // Random bytes, random gaps, random downstream stalls
        ovr_cnt = 0;
        exp_q.delete();
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            b = (i == 5) ? 8'h0A : 8'($urandom);
            idle($urandom_range(0, 20));
            send_frame(b, 1'b1, t0);
            exp_q.push_back(b);
        end
        idle(20);
        rand_ready = 1'b0;
        idle(3);
        tready = 1'b1;
        idle(20);
        check("rand_count", 32'(rx_q.size()), 12);
        check("rand_overrun", 32'(ovr_cnt), 0);
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            b = exp_q.pop_front();
            expect_rx("rand", b, (b == 8'h0A));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
